// File: rtl/udp_tx_sched_pkg.sv
// rtl/udp_tx_sched_pkg.sv - result codes and FSM states shared by the UDP TX scheduler
package udp_tx_sched_pkg;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_SENDING = 2'b01;
  localparam logic [1:0] RES_ERR     = 2'b10;
  localparam logic [1:0] RES_SENT    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first requester after last_winner
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_winner,
  output logic [NUM_PORTS-1:0] winner,
  output logic                 valid
);

  logic [IDX_W-1:0] p;

  // Scan starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    p      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      p = IDX_W'((int'(last_winner) + i) % NUM_PORTS);
      if (!valid && req[p]) begin
        winner[p] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_rr_scheduler.sv
// rtl/udp_tx_rr_scheduler.sv - round-robin grant of the UDP TX core with second-tick watchdog
// Per-port SENT/ERR counters are added when UDP_TX_SCHED_STATS_EN is defined.
module udp_tx_rr_scheduler #(
  parameter int NUM_PORTS    = 4,
  parameter int WDOG_SECONDS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         second,
  input  logic [NUM_PORTS-1:0]         req,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic [2*NUM_PORTS-1:0]       port_result,
  output logic                         udp_tx_start,
  input  logic [1:0]                   udp_tx_result,
  output logic                         busy,
  output logic [7:0]                   wdog_aborts
`ifdef UDP_TX_SCHED_STATS_EN
  ,
  output logic [16*NUM_PORTS-1:0]      sent_count,
  output logic [16*NUM_PORTS-1:0]      err_count
`endif
);
  import udp_tx_sched_pkg::*;

  localparam int          IDX_W    = $clog2(NUM_PORTS);
  localparam logic [15:0] WD_LIMIT = 16'(WDOG_SECONDS);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       last_winner_q, last_winner_d;
  logic [2*NUM_PORTS-1:0] port_result_q, port_result_d;
  logic                   udp_tx_start_q, udp_tx_start_d;
  logic                   busy_q, busy_d;
  logic [7:0]             wdog_aborts_q, wdog_aborts_d;
  logic [15:0]            wdog_cnt_q, wdog_cnt_d;
  logic [1:0]             code_q, code_d;

  logic [NUM_PORTS-1:0]   pick_onehot;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   wdog_fire;
  logic                   core_done;
  logic                   abort;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner_q),
    .winner      (pick_onehot),
    .valid       (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  assign wdog_fire = second && ((wdog_cnt_q + 16'd1) == WD_LIMIT);
  assign core_done = (udp_tx_result == RES_SENT) || (udp_tx_result == RES_ERR);

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    grant_idx_d    = grant_idx_q;
    last_winner_d  = last_winner_q;
    udp_tx_start_d = 1'b0;
    wdog_cnt_d     = wdog_cnt_q;
    wdog_aborts_d  = wdog_aborts_q;
    code_d         = code_q;
    abort          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_GRANT;
          gnt_d       = pick_onehot;
          grant_idx_d = pick_idx;
          wdog_cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        state_d        = ST_START;
        udp_tx_start_d = 1'b1;
      end
      ST_START: begin
        if (wdog_fire) begin
          abort = 1'b1;
        end else begin
          if (second) wdog_cnt_d = wdog_cnt_q + 16'd1;
          if (udp_tx_result == RES_SENDING) state_d = ST_WAIT;
          else udp_tx_start_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // A core completion in the same cycle as the final tick wins over the abort.
        if (core_done) begin
          code_d  = udp_tx_result;
          state_d = ST_RELEASE;
        end else if (wdog_fire) begin
          abort = 1'b1;
        end else if (second) begin
          wdog_cnt_d = wdog_cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (!req[grant_idx_q]) begin
          state_d       = ST_IDLE;
          gnt_d         = '0;
          grant_idx_d   = '0;
          last_winner_d = grant_idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      code_d  = RES_ERR;
      state_d = ST_RELEASE;
      if (wdog_aborts_q != 8'hFF) wdog_aborts_d = wdog_aborts_q + 8'd1;
    end
    busy_d        = (state_d != ST_IDLE);
    port_result_d = '0;
    if (state_d == ST_START || state_d == ST_WAIT) port_result_d[2*grant_idx_d +: 2] = RES_SENDING;
    else if (state_d == ST_RELEASE) port_result_d[2*grant_idx_d +: 2] = code_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      gnt_q          <= '0;
      grant_idx_q    <= '0;
      last_winner_q  <= IDX_W'(NUM_PORTS - 1);
      port_result_q  <= '0;
      udp_tx_start_q <= 1'b0;
      busy_q         <= 1'b0;
      wdog_aborts_q  <= '0;
      wdog_cnt_q     <= '0;
      code_q         <= RES_NONE;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      grant_idx_q    <= grant_idx_d;
      last_winner_q  <= last_winner_d;
      port_result_q  <= port_result_d;
      udp_tx_start_q <= udp_tx_start_d;
      busy_q         <= busy_d;
      wdog_aborts_q  <= wdog_aborts_d;
      wdog_cnt_q     <= wdog_cnt_d;
      code_q         <= code_d;
    end
  end

  assign gnt          = gnt_q;
  assign grant_idx    = grant_idx_q;
  assign port_result  = port_result_q;
  assign udp_tx_start = udp_tx_start_q;
  assign busy         = busy_q;
  assign wdog_aborts  = wdog_aborts_q;

`ifdef UDP_TX_SCHED_STATS_EN
  logic [15:0] sent_q [NUM_PORTS];
  logic [15:0] sent_d [NUM_PORTS];
  logic [15:0] err_q  [NUM_PORTS];
  logic [15:0] err_d  [NUM_PORTS];
  logic        finish_xfer;

  assign finish_xfer = (state_q != ST_RELEASE) && (state_d == ST_RELEASE);

  always_comb begin
    sent_d = sent_q;
    err_d  = err_q;
    if (finish_xfer) begin
      if (code_d == RES_SENT) sent_d[grant_idx_q] = sent_q[grant_idx_q] + 16'd1;
      else err_d[grant_idx_q] = err_q[grant_idx_q] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        sent_q[i] <= '0;
        err_q[i]  <= '0;
      end
    end else begin
      sent_q <= sent_d;
      err_q  <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stats
    assign sent_count[16*g +: 16] = sent_q[g];
    assign err_count[16*g +: 16]  = err_q[g];
  end
`endif

endmodule

// File: doc/udp_tx_rr_scheduler.md
UDP_TX_RR_SCHEDULER -- requirements
Module: udp_tx_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of UDP transmit requesters, range 2..8.
REQ-002 SHALL have parameter WDOG_SECONDS, default 2: number of second ticks a granted transfer may run before it is aborted.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- second  in  1  one-cycle tick, once per second.
- req  in  NUM_PORTS  per-port start request, level; held high until the port sees its result.
- gnt  out  NUM_PORTS  one-hot grant; selects the header/data mux.
- grant_idx  out  clog2(NUM_PORTS)  binary index of the granted port; 0 when idle.
- port_result  out  2*NUM_PORTS  per-port result, 2 bits per port.
- udp_tx_start  out  1  start strobe to the UDP core.
- udp_tx_result  in  2  UDP core result code.
- busy  out  1  a grant is held.
- wdog_aborts  out  8  saturating count of watchdog aborts.

Function
REQ-005 Result codes SHALL be: NONE=00, SENDING=01, ERR=10, SENT=11.
REQ-006 The state machine SHALL have the states IDLE, GRANT, START, WAIT and RELEASE.
REQ-007 In IDLE with any req high, the block SHALL pick the first requesting port at or after last_winner+1 (mod NUM_PORTS), assert its gnt on the next cycle and enter GRANT.
REQ-008 GRANT SHALL last exactly 1 cycle so the mux settles, then go to START.
REQ-009 START SHALL assert udp_tx_start and stay until udp_tx_result==SENDING, then go to WAIT.
REQ-010 From IDLE with req high, udp_tx_start SHALL first assert 2 cycles after req.
REQ-011 In WAIT, on udp_tx_result SENT or ERR, the block SHALL latch that code into the granted port's port_result field and enter RELEASE.
REQ-012 In RELEASE the block SHALL hold gnt until the granted req drops, then clear gnt, update last_winner and return to IDLE.
REQ-013 port_result for a port SHALL read NONE while the port is ungranted, SENDING during START and WAIT, and the latched code during RELEASE.
REQ-014 If the granted req drops before RELEASE (requester withdraws), the block SHALL still complete the sequence and SHALL release immediately on entering RELEASE.
REQ-015 The watchdog SHALL count second ticks while in START or WAIT.
REQ-016 When the watchdog count reaches WDOG_SECONDS, the block SHALL force ERR for the granted port, enter RELEASE, and increment wdog_aborts, saturating at 255.
REQ-017 The watchdog count SHALL clear on entering GRANT.
REQ-018 A req arriving during a grant SHALL wait, with no preemption.
REQ-019 Simultaneous requests SHALL be resolved by the round-robin pointer only.
REQ-020 A single requester SHALL be re-granted back-to-back, with 1 IDLE cycle between grants.
REQ-021 udp_tx_result values SENT or ERR seen outside WAIT SHALL be ignored.

Reset
REQ-022 On reset, the block SHALL enter IDLE and drive gnt=0, grant_idx=0, port_result=0, udp_tx_start=0, busy=0 and wdog_aborts=0.
REQ-023 On reset, last_winner SHALL be set to NUM_PORTS-1, so port 0 has priority first.
REQ-024 Reset asserted mid-transfer SHALL drop udp_tx_start and gnt asynchronously.

Configuration
REQ-025 With UDP_TX_SCHED_STATS_EN defined, the block SHALL add an output sent_count (16*NUM_PORTS) holding per-port wrapping counts of SENT results.
REQ-026 With UDP_TX_SCHED_STATS_EN defined, the block SHALL add an output err_count (16*NUM_PORTS) holding per-port wrapping counts of ERR results, including watchdog aborts.
REQ-027 Without UDP_TX_SCHED_STATS_EN, those ports and counters SHALL be absent.
REQ-028 Scheduling behaviour SHALL be identical with or without UDP_TX_SCHED_STATS_EN.

Structure
REQ-029 Package udp_tx_sched_pkg SHALL hold the result-code constants and the state enumeration.
REQ-030 Round-robin selection SHALL be a sub-module, rr_pick: combinational, taking req and last_winner and producing a one-hot winner plus a valid flag.

Verification
REQ-031 Simultaneous req: req=4'b1011 from reset -> grants in order port 0, 1, 3, each completed with SENT; port_result for each port = 11 during its RELEASE.
REQ-032 Fairness: port 2 requests continuously while port 0 re-requests after every release -> grants alternate 0, 2, 0, 2.
REQ-033 Core error: udp_tx_result=10 during WAIT -> granted port_result=10, gnt held until req drops, wdog_aborts unchanged.
REQ-034 Watchdog: core stays SENDING for 2 second ticks -> ERR forced at the 2nd tick, wdog_aborts=1, release once req drops.
REQ-035 Reset mid-WAIT: reset asserted -> udp_tx_start=0 and gnt=0 in the same cycle; after reset release with req=4'b0100, port 2 is granted and udp_tx_start asserts 2 cycles after the first clock edge with req sampled high.
REQ-036 With UDP_TX_SCHED_STATS_EN: 3 SENT and 1 ERR on port 1 -> sent_count[1]=3, err_count[1]=1, all other counts 0.
